// File: rtl/core_pkg.sv
// Shared core types: physical-register tag, reclaim-queue entry and walk state.
// Consumed by the reclaim queue and anything that talks to the free list.
package core_pkg;

  localparam int PREGS = 64;
  localparam int PW    = $clog2(PREGS);

  typedef logic [PW-1:0] preg_t;

  typedef struct packed {
    preg_t old_phys;
    preg_t new_phys;
  } reclaim_entry_t;

  typedef enum logic {
    RQ_IDLE = 1'b0,
    RQ_WALK = 1'b1
  } reclaim_state_t;

endpackage

// File: rtl/preg_reclaim_queue_sva.sv
// Protocol checker for preg_reclaim_queue; attached to the design by bind.
// Flags commits into an empty queue and two frees competing for the single return port.
module preg_reclaim_queue_sva (
  input logic clk,
  input logic reset,
  input logic idle,
  input logic empty,
  input logic commit_en,
  input logic commit_free,
  input logic walk_free
);

  // A commit request while idle and empty has nothing to retire
  a_commit_not_empty: assert property (
    @(posedge clk) disable iff (!reset) !(idle && empty && commit_en)
  );

  // Only one source may drive the free list return port per cycle
  a_one_free_source: assert property (
    @(posedge clk) disable iff (!reset) !(commit_free && walk_free)
  );

endmodule

// File: rtl/preg_reclaim_queue.sv
// Program-order queue of {old_phys,new_phys} pairs: frees old tags at commit and
// walks youngest->oldest on flush returning squashed new tags, one per cycle.
module preg_reclaim_queue
  import core_pkg::*;
#(
  parameter int PHYS_REGS = PREGS,
  parameter int DEPTH     = 32,
  localparam int PW_L     = $clog2(PHYS_REGS),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enq_en,
  input  logic [PW_L-1:0] enq_old_phys,
  input  logic [PW_L-1:0] enq_new_phys,
  output logic            enq_ready,
  input  logic            commit_en,
  output logic            commit_ready,
  input  logic            flush_en,
  output logic            busy,
  output logic            free_en,
  output logic [PW_L-1:0] free_phys,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  reclaim_state_t  state_r, state_nxt_s;
  logic [AW-1:0]   head_r, head_nxt_s;
  logic [AW-1:0]   tail_r, tail_nxt_s, tail_dec_s;
  logic [CW-1:0]   count_r, count_nxt_s, count_cm_s;
  logic            free_en_r, free_en_nxt_s;
  logic [PW_L-1:0] free_phys_r, free_phys_nxt_s;
  logic            busy_r;
  logic            idle_s, full_s, empty_s;
  logic            enq_do_s, commit_do_s, walk_pop_s;
  reclaim_entry_t  mem_r [DEPTH];

  assign idle_s     = (state_r == RQ_IDLE);
  assign full_s     = (count_r == CW'(DEPTH));
  assign empty_s    = (count_r == CW'(0));
  assign tail_dec_s = tail_r - AW'(1);

  // Transfer decisions; a flush in idle drops the same-edge enqueue
  always_comb begin
    commit_do_s = idle_s && commit_en && !empty_s;
    enq_do_s    = idle_s && enq_en && !full_s && !flush_en;
    walk_pop_s  = (state_r == RQ_WALK);
  end

  // Next pointers, count, state and the single free-port request
  always_comb begin
    state_nxt_s     = state_r;
    head_nxt_s      = head_r;
    tail_nxt_s      = tail_r;
    count_nxt_s     = count_r;
    count_cm_s      = count_r;
    free_en_nxt_s   = 1'b0;
    free_phys_nxt_s = free_phys_r;
    case (state_r)
      RQ_IDLE: begin
        // The commit is older than any flush point, so it retires first
        if (commit_do_s) begin
          head_nxt_s      = head_r + AW'(1);
          count_cm_s      = count_r - CW'(1);
          free_en_nxt_s   = 1'b1;
          free_phys_nxt_s = mem_r[head_r].old_phys;
        end else begin
          count_cm_s      = count_r;
        end
        if (flush_en) begin
          count_nxt_s = count_cm_s;
          if (count_cm_s != CW'(0)) begin
            state_nxt_s = RQ_WALK;
          end else begin
            state_nxt_s = RQ_IDLE;
          end
        end else if (enq_do_s) begin
          tail_nxt_s  = tail_r + AW'(1);
          count_nxt_s = count_cm_s + CW'(1);
        end else begin
          count_nxt_s = count_cm_s;
        end
      end
      RQ_WALK: begin
        tail_nxt_s      = tail_dec_s;
        count_nxt_s     = count_r - CW'(1);
        free_en_nxt_s   = 1'b1;
        free_phys_nxt_s = mem_r[tail_dec_s].new_phys;
        if (count_r == CW'(1)) begin
          state_nxt_s = RQ_IDLE;
        end else begin
          state_nxt_s = RQ_WALK;
        end
      end
      default: begin
        state_nxt_s = RQ_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RQ_IDLE;
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      free_en_r   <= 1'b0;
      free_phys_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      count_r     <= count_nxt_s;
      free_en_r   <= free_en_nxt_s;
      free_phys_r <= free_phys_nxt_s;
      busy_r      <= (state_nxt_s == RQ_WALK);
    end
  end

  // Entry storage; contents are only meaningful between head and tail
  always_ff @(posedge clk) begin
    if (enq_do_s) begin
      mem_r[tail_r] <= '{old_phys: enq_old_phys, new_phys: enq_new_phys};
    end
  end

  assign enq_ready    = !full_s && idle_s;
  assign commit_ready = !empty_s && idle_s;
  assign busy         = busy_r;
  assign free_en      = free_en_r;
  assign free_phys    = free_phys_r;
  assign count        = count_r;

endmodule
